wb_stage: RTL
=============

# wb_stage

Writeback stage of the in-order core. Accepts one retiring instruction per cycle from the memory stage, selects the writeback value (ALU result, aligned load data, or PC+4), and drives the register file write port. Loads whose data has not yet arrived are held in a one-entry wait state that back-pressures the memory stage. All register-file write outputs are registered on the rising edge, so the register file's falling-edge write lands mid-cycle.

## Interface

- DATA_WIDTH, 32, datapath width
- RD_WIDTH, 5, destination register index width
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept; 0 while rst_n low or in WAIT_LOAD
- in_reg_we  in  1  instruction writes a register
- in_rd  in  RD_WIDTH  destination index
- in_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 treated as ALU
- in_alu_res  in  DATA_WIDTH  ALU result
- in_pc  in  DATA_WIDTH  instruction PC
- in_funct3  in  3  load type
- in_addr_lo  in  2  load byte address bits [1:0]
- mem_rvalid  in  1  data memory read response valid (single-cycle pulse)
- mem_rdata  in  DATA_WIDTH  raw 32-bit word from data memory
- rf_we  out  1  register file write enable
- rf_wa  out  RD_WIDTH  write address
- rf_wd  out  DATA_WIDTH  write data
- retire  out  1  one-cycle pulse per committed instruction
- pend_valid  out  1  load pending in WAIT_LOAD (for hazard unit)
- pend_rd  out  RD_WIDTH  destination of pending load; 0 when pend_valid=0

## Operation

- States: IDLE, WAIT_LOAD. Reset state IDLE.
- Handshake: transfer when in_valid && in_ready. in_ready = rst_n && (state==IDLE), combinational.
- IDLE, transfer, in_wb_sel != 01: commit immediately. Value = in_alu_res, or in_pc+4 (mod 2^32). Stay IDLE.
- IDLE, transfer, in_wb_sel == 01, mem_rvalid=1 same cycle: commit aligned mem_rdata. Stay IDLE.
- IDLE, transfer, load, mem_rvalid=0: latch rd, reg_we, funct3, addr_lo. Go to WAIT_LOAD.
- WAIT_LOAD: in_ready=0. On mem_rvalid: commit aligned data from latched fields, go to IDLE. No timeout.
- mem_rvalid in IDLE with no load transferring that cycle: ignored.
- Commit: rf_we <= reg_we && rd != 0 (x0 writes suppressed, but retire still pulses). rf_wa <= rd, rf_wd <= value, retire <= 1. When there is no commit in a cycle, rf_we and retire go to 0 and rf_wa/rf_wd hold.
- Load alignment by funct3:
  - 000 LB: byte at addr_lo, sign-extended.
  - 001 LH: halfword at addr_lo[1], sign-extended.
  - 010 LW: full word; addr_lo ignored.
  - 100 LBU: byte at addr_lo, zero-extended.
  - 101 LHU: halfword at addr_lo[1], zero-extended.
  - Other encodings: full word.
  - Halfword loads ignore addr_lo[0]; misalignment is not trapped here.
- pend_valid = (state==WAIT_LOAD). pend_rd = latched rd in WAIT_LOAD, else 0.

## Timing

- Reset (asynchronous, any cycle): state=IDLE; rf_we=0, rf_wa=0, rf_wd=0, retire=0; latched fields cleared. A load pending in WAIT_LOAD is discarded with no write.
- Non-load latency: transfer in cycle N gives rf_we/retire high in cycle N+1, for exactly one cycle.
- Load latency: mem_rvalid in cycle M (M ≥ transfer cycle) gives commit in cycle M+1.
- Throughput: one commit per cycle for back-to-back non-loads, and for loads with same-cycle mem_rvalid.
- Commit outputs are stable for the whole cycle; the register file samples them on the falling edge of that cycle.
- Re-acceptance: the WAIT_LOAD→IDLE transition happens on the edge after mem_rvalid. in_ready rises in the same cycle that the load's commit is visible.

## Test plan

- Reset release, then ALU op: rd=5, alu_res=0x1234_5678 -> next cycle rf_we=1, rf_wa=5, rf_wd=0x12345678, retire=1; low the cycle after.
- JAL-style: wb_sel=10, pc=0xFFFF_FFFC, rd=1 -> rf_wd=0x0000_0000 (wrap), rf_we=1.
- Load alignment: mem_rdata=0x80FF_7F01, same-cycle rvalid. Expected rf_wd:
  - LB addr_lo=3 -> 0xFFFF_FF80
  - LBU addr_lo=3 -> 0x0000_0080
  - LH addr_lo=2 -> 0xFFFF_80FF
  - LHU addr_lo=0 -> 0x0000_7F01
  - LW -> 0x80FF_7F01
- Delayed load: LW rd=7 transferred, mem_rvalid 3 cycles later with 0xDEAD_BEEF -> in_ready=0 and pend_valid=1, pend_rd=7 for 3 cycles; commit rf_wa=7, rf_wd=0xDEADBEEF one cycle after rvalid; a following in_valid is accepted only once back in IDLE.
- x0 and stray response: ALU op rd=0 -> retire=1, rf_we=0; unsolicited mem_rvalid in IDLE -> no rf_we, no retire.
- Reset mid-wait: load in WAIT_LOAD, assert rst_n low asynchronously, then deliver mem_rvalid after release -> no write, state IDLE, all outputs 0.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: picks ALU / aligned load / PC+4 and registers the regfile write port.
// Commit is visible one cycle after transfer (or after mem_rvalid); in_ready drops while a load waits.
module wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_reg_we,
  input  logic [RD_WIDTH-1:0]   in_rd,
  input  logic [1:0]            in_wb_sel,
  input  logic [DATA_WIDTH-1:0] in_alu_res,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [2:0]            in_funct3,
  input  logic [1:0]            in_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_we,
  output logic [RD_WIDTH-1:0]   rf_wa,
  output logic [DATA_WIDTH-1:0] rf_wd,
  output logic                  retire,
  output logic                  pend_valid,
  output logic [RD_WIDTH-1:0]   pend_rd
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t                r_state;
  logic                  r_we;
  logic [RD_WIDTH-1:0]   r_rd;
  logic [2:0]            r_funct3;
  logic [1:0]            r_addr_lo;

  logic                  w_xfer;
  logic                  w_commit;
  logic                  w_go_wait;
  logic                  w_we;
  logic [RD_WIDTH-1:0]   w_rd;
  logic [DATA_WIDTH-1:0] w_val;

  // Halfword loads use only addr_lo[1]; unknown funct3 returns the raw word.
  function automatic logic [DATA_WIDTH-1:0] align_load(
    input logic [2:0]            f3,
    input logic [1:0]            lo,
    input logic [DATA_WIDTH-1:0] w
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lo +: 8];
    h = lo[1] ? w[16 +: 16] : w[0 +: 16];
    case (f3)
      3'b000:  return {{(DATA_WIDTH-8){b[7]}}, b};
      3'b001:  return {{(DATA_WIDTH-16){h[15]}}, h};
      3'b100:  return {{(DATA_WIDTH-8){1'b0}}, b};
      3'b101:  return {{(DATA_WIDTH-16){1'b0}}, h};
      default: return w;
    endcase
  endfunction

  assign in_ready   = rst_n && (r_state == IDLE);
  assign w_xfer     = in_valid && in_ready;
  assign pend_valid = (r_state == WAIT_LOAD);
  assign pend_rd    = (r_state == WAIT_LOAD) ? r_rd : '0;

  always_comb begin
    w_commit  = 1'b0;
    w_go_wait = 1'b0;
    w_we      = in_reg_we;
    w_rd      = in_rd;
    w_val     = in_alu_res;
    if (r_state == WAIT_LOAD) begin
      w_commit = mem_rvalid;
      w_we     = r_we;
      w_rd     = r_rd;
      w_val    = align_load(r_funct3, r_addr_lo, mem_rdata);
    end else if (w_xfer) begin
      if (in_wb_sel == 2'b01) begin
        w_commit  = mem_rvalid;
        w_go_wait = !mem_rvalid;
        w_val     = align_load(in_funct3, in_addr_lo, mem_rdata);
      end else begin
        w_commit = 1'b1;
        if (in_wb_sel == 2'b10) w_val = in_pc + DATA_WIDTH'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_rd      <= '0;
      r_funct3  <= '0;
      r_addr_lo <= '0;
      rf_we     <= 1'b0;
      rf_wa     <= '0;
      rf_wd     <= '0;
      retire    <= 1'b0;
    end else begin
      rf_we  <= 1'b0;
      retire <= 1'b0;
      if (w_commit) begin
        rf_we  <= w_we && (w_rd != '0);
        rf_wa  <= w_rd;
        rf_wd  <= w_val;
        retire <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_go_wait) begin
            r_state   <= WAIT_LOAD;
            r_we      <= in_reg_we;
            r_rd      <= in_rd;
            r_funct3  <= in_funct3;
            r_addr_lo <= in_addr_lo;
          end
        end
        WAIT_LOAD: begin
          if (mem_rvalid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
